// File: rtl/gate_input_debouncer_pkg.sv
// Shared constants for the gate-network input conditioning stage.
// Channel indices map switch inputs A..G onto bus bits 0..6.
package gate_in_pkg;

  localparam int NUM_CH = 7;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;
  localparam int CH_E = 4;
  localparam int CH_F = 5;
  localparam int CH_G = 6;

  localparam int DEF_TICK_DIV     = 1000;
  localparam int DEF_STABLE_TICKS = 8;

endpackage

// File: rtl/gate_input_debouncer_channel.sv
// One debounced switch bit: two-flop synchroniser, stability counter,
// registered clean level and one-cycle change flag.
module debounce_channel #(
  parameter int   STABLE_TICKS = 8,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic change,
  output logic flip
);

  localparam int CW =
    (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          mismatch;

  assign mismatch = sync2 != level;
  assign flip     = mismatch && tick && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= RESET_VAL;
      sync2  <= RESET_VAL;
      level  <= RESET_VAL;
      cnt    <= '0;
      change <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      change <= flip;
      // any agreement restarts the window, tick or not
      if (!mismatch) begin
        cnt <= '0;
      end else if (tick) begin
        if (flip) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gate_input_debouncer.sv
// Seven-channel switch debouncer feeding the gate network; shared
// sample-tick prescaler plus per-channel filters and change reporting.
module gate_input_debouncer #(
  parameter int NUM_CH       = gate_in_pkg::NUM_CH,
  parameter int TICK_DIV     = gate_in_pkg::DEF_TICK_DIV,
  parameter int STABLE_TICKS = gate_in_pkg::DEF_STABLE_TICKS,
  parameter logic [NUM_CH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] sw_in,
  output logic [NUM_CH-1:0] sw_out,
  output logic [NUM_CH-1:0] change_mask,
  output logic              change_pulse
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]     count;
  logic              tick;
  logic [NUM_CH-1:0] flip;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (sw_in[i]),
      .level (sw_out[i]),
      .change(change_mask[i]),
      .flip  (flip[i])
    );
  end

  // registered from the same next-state terms, so it lines up with change_mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_pulse <= 1'b0;
    end else begin
      change_pulse <= |flip;
    end
  end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Directed bench: u1 runs TICK_DIV=1/STABLE_TICKS=4,
// u5 runs TICK_DIV=5/STABLE_TICKS=3.
module tb_gate_input_debouncer;
  import gate_in_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en1 = 1'b1;
  logic       en5 = 1'b1;
  logic [6:0] sw1 = '0;
  logic [6:0] sw5 = '0;
  logic [6:0] out1, mask1, out5, mask5;
  logic       pulse1, pulse5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_input_debouncer #(
    .NUM_CH(7), .TICK_DIV(1), .STABLE_TICKS(4), .RESET_VAL(7'h00)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .sw_in(sw1),
    .sw_out(out1), .change_mask(mask1), .change_pulse(pulse1)
  );

  gate_input_debouncer #(
    .NUM_CH(7), .TICK_DIV(5), .STABLE_TICKS(3), .RESET_VAL(7'h00)
  ) u5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .sw_in(sw5),
    .sw_out(out5), .change_mask(mask5), .change_pulse(pulse5)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat;

    // 1: reset with all inputs high
    sw1 = 7'h7F;
    step(3);
    chk("rst_out", 32'(out1), 32'h00);
    chk("rst_mask", 32'(mask1), 32'h00);
    chk("rst_pulse", 32'(pulse1), 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_out", 32'(out1), 32'h00);
    chk("post_rst_mask", 32'(mask1), 32'h00);
    step(4);
    chk("pre_filter_out", 32'(out1), 32'h00);
    step(1);
    chk("filter_out", 32'(out1), 32'h7F);
    chk("filter_mask", 32'(mask1), 32'h7F);
    sw1 = 7'h00;
    step(10);
    chk("back_low", 32'(out1), 32'h00);

    // 2: clean step on C; flip on 6th edge after setting input
    sw1[CH_C] = 1'b1;
    step(5);
    chk("step_c_early", 32'(out1), 32'h00);
    chk("step_c_nopulse", 32'(pulse1), 32'h0);
    step(1);
    chk("step_c_out", 32'(out1), 32'h04);
    chk("step_c_mask", 32'(mask1), 32'h04);
    chk("step_c_pulse", 32'(pulse1), 32'h1);
    step(1);
    chk("step_c_mask_clr", 32'(mask1), 32'h00);
    chk("step_c_pulse_clr", 32'(pulse1), 32'h0);
    chk("step_c_hold", 32'(out1), 32'h04);

    // 3: bounce on E never survives the window
    sw1[CH_E] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bounce_p1", 32'(pulse1), 32'h0);
    end
    sw1[CH_E] = 1'b0;
    step(1);
    chk("bounce_p2", 32'(pulse1), 32'h0);
    sw1[CH_E] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bounce_p3", 32'(pulse1), 32'h0);
    end
    sw1[CH_E] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("bounce_p4", 32'(pulse1), 32'h0);
    end
    chk("bounce_out", 32'(out1), 32'h04);

    // 4: two channels together
    sw1 = 7'h00;
    step(10);
    chk("clear_c", 32'(out1), 32'h00);
    sw1 = 7'h41;
    step(5);
    chk("simul_early", 32'(out1), 32'h00);
    step(1);
    chk("simul_out", 32'(out1), 32'h41);
    chk("simul_mask", 32'(mask1), 32'h41);
    chk("simul_pulse", 32'(pulse1), 32'h1);
    step(1);
    chk("simul_mask_clr", 32'(mask1), 32'h00);

    // 5: prescaled channel A, then en freeze mid-count
    sw5[CH_A] = 1'b1;
    lat = 0;
    while (lat < 20 && out5[CH_A] !== 1'b1) begin
      step(1);
      lat++;
    end
    chk("presc_lat_min", 32'(lat >= 13), 32'h1);
    chk("presc_lat_max", 32'(lat <= 17), 32'h1);
    chk("presc_mask", 32'(mask5), 32'h01);
    chk("presc_pulse", 32'(pulse5), 32'h1);
    // flip edge was a tick; ticks follow every 5 edges
    sw5[CH_A] = 1'b0;
    step(11);
    chk("presc_pre_freeze", 32'(out5), 32'h01);
    en5 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("freeze_pulse", 32'(pulse5), 32'h0);
    end
    chk("freeze_out", 32'(out5), 32'h01);
    en5 = 1'b1;
    step(3);
    chk("resume_early", 32'(out5), 32'h01);
    step(1);
    chk("resume_out", 32'(out5), 32'h00);
    chk("resume_mask", 32'(mask5), 32'h01);

    // 6: reset with C one tick from flipping
    sw1 = 7'h45;
    step(5);
    chk("pre_rst_hold", 32'(out1), 32'h41);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out1), 32'h00);
    chk("async_rst_mask", 32'(mask1), 32'h00);
    #2;
    rst_n = 1'b1;
    step(5);
    chk("rewindow_early", 32'(out1), 32'h00);
    step(1);
    chk("rewindow_out", 32'(out1), 32'h45);
    chk("rewindow_mask", 32'(mask1), 32'h45);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
